// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding and
// the bit-counter width helper.
package seq_mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/sa_iter_step.sv
// One conditional shift-add iteration: adds the zero-extended magnitude,
// shifted by the bit index, when the selected multiplier bit is set.
module sa_iter_step
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 64,
  localparam int RESULT_W = 2 * WIDTH,
  localparam int CNT_W = cnt_w(WIDTH)
) (
  input  logic [RESULT_W-1:0] acc,
  input  logic [WIDTH-1:0]    mag,
  input  logic                mult_bit,
  input  logic [CNT_W-1:0]    idx,
  output logic [RESULT_W-1:0] acc_next
);

  logic [RESULT_W-1:0] addend;

  assign addend   = {{WIDTH{1'b0}}, mag} << idx;
  assign acc_next = mult_bit ? (acc + addend) : acc;

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, signed mode
// multiplies magnitudes and negates the final sum.
module seq_shift_add_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int RESULT_W = 2 * WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic                signed_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RESULT_W-1:0] result
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0]    LAST  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]    ONE_C = CNT_W'(1);
  localparam logic [WIDTH-1:0]    ONE_W = WIDTH'(1);
  localparam logic [RESULT_W-1:0] ONE_R = RESULT_W'(1);

  logic [1:0]          state;
  logic [WIDTH-1:0]    mag_a;
  logic [WIDTH-1:0]    mag_b;
  logic [RESULT_W-1:0] acc;
  logic [RESULT_W-1:0] acc_next;
  logic [CNT_W-1:0]    cnt;
  logic                neg;

  // -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits the unsigned register.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic sm);
    return (sm && v[WIDTH-1]) ? (~v + ONE_W) : v;
  endfunction

  function automatic logic [RESULT_W-1:0] apply_sign(input logic [RESULT_W-1:0] sum,
                                                     input logic n);
    return n ? (~sum + ONE_R) : sum;
  endfunction

  sa_iter_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .mag      (mag_a),
    .mult_bit (mag_b[cnt]),
    .idx      (cnt),
    .acc_next (acc_next)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // Operand magnitudes are pure data and only change on accept.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && in_valid) begin
      mag_a <= magnitude(a, signed_mode);
      mag_b <= magnitude(b, signed_mode);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc   <= '0;
            cnt   <= '0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          acc <= acc_next;
          cnt <= cnt + ONE_C;
          if (cnt == LAST) begin
            result <= apply_sign(acc_next, neg);
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult: directed cases at WIDTH=8, randomized products
// at WIDTH=8 and WIDTH=64 against an arithmetic reference model.
module tb_seq_shift_add_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8, iv8, ir8, sm8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;

  logic         rst64, iv64, ir64, sm64, ov64, or64;
  logic [63:0]  a64, b64;
  logic [127:0] res64;

  int checks = 0;
  int errors = 0;

  seq_shift_add_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .result(res8)
  );

  seq_shift_add_mult #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst64), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
    .signed_mode(sm64), .out_valid(ov64), .out_ready(or64), .result(res64)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: ordinary multiplication of sign- or zero-extended operands.
  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic sm);
    logic signed [15:0] sx, sy;
    if (sm) begin sx = $signed(x); sy = $signed(y); end
    else begin sx = {8'b0, x}; sy = {8'b0, y}; end
    return 16'(sx * sy);
  endfunction

  function automatic logic [127:0] ref64(input logic [63:0] x, input logic [63:0] y, input logic sm);
    logic signed [127:0] sx, sy;
    if (sm) begin sx = $signed(x); sy = $signed(y); end
    else begin sx = {64'b0, x}; sy = {64'b0, y}; end
    return 128'(sx * sy);
  endfunction

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic sm,
                     input int stall, input string tag);
    logic [15:0] exp;
    exp = ref8(x, y, sm);
    @(negedge clk);
    a8 = x; b8 = y; sm8 = sm; iv8 = 1'b1;
    check({tag, " in_ready"}, 128'(ir8), 128'(1));
    @(posedge clk); #1;
    iv8 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 7) check({tag, " not_early"}, 128'(ov8), 128'(0));
    end
    check({tag, " valid"}, 128'(ov8), 128'(1));
    check({tag, " result"}, 128'(res8), 128'(exp));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check({tag, " stall_result"}, 128'(res8), 128'(exp));
      check({tag, " stall_ready"}, 128'({ir8, ov8}), 128'(2'b01));
    end
    @(negedge clk); or8 = 1'b1;
    @(posedge clk); #1; or8 = 1'b0;
    check({tag, " handoff"}, 128'({ir8, ov8}), 128'(2'b10));
  endtask

  task automatic op64(input logic [63:0] x, input logic [63:0] y, input logic sm,
                      input string tag);
    logic [127:0] exp;
    exp = ref64(x, y, sm);
    @(negedge clk);
    a64 = x; b64 = y; sm64 = sm; iv64 = 1'b1;
    check({tag, " in_ready"}, 128'(ir64), 128'(1));
    @(posedge clk); #1;
    iv64 = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk); #1;
      if (k == 63) check({tag, " not_early"}, 128'(ov64), 128'(0));
    end
    check({tag, " valid"}, 128'(ov64), 128'(1));
    check({tag, " result"}, res64, exp);
    @(negedge clk); or64 = 1'b1;
    @(posedge clk); #1; or64 = 1'b0;
    check({tag, " handoff"}, 128'({ir64, ov64}), 128'(2'b10));
  endtask

  initial begin
    int seen;
    rst8 = 1'b1; iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0;
    rst64 = 1'b1; iv64 = 1'b0; or64 = 1'b0; a64 = '0; b64 = '0; sm64 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset8", 128'({ir8, ov8, res8}), 128'({2'b10, 16'h0}));
    check("reset64", {126'(0), ir64, ov64}, 128'(2'b10));
    check("reset64_result", res64, 128'(0));
    @(negedge clk); rst8 = 1'b0; rst64 = 1'b0;

    // Directed WIDTH=8 products, including back-pressure and zero operands.
    op8(8'hFF, 8'hFF, 1'b0, 20, "u_ff_ff");
    op8(8'h80, 8'h80, 1'b1, 0, "s_min_min");
    op8(8'hF9, 8'h06, 1'b1, 0, "s_m7_6");
    op8(8'h00, 8'hA5, 1'b1, 0, "zero_a");
    op8(8'h5A, 8'h00, 1'b0, 0, "zero_b");
    op8(8'h80, 8'h01, 1'b1, 0, "s_min_one");

    // Abort mid-BUSY: no result ever appears, block ready right after reset.
    @(negedge clk); a8 = 8'd5; b8 = 8'd3; sm8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1; iv8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst8 = 1'b1;
    @(posedge clk); #1;
    check("abort_reset", 128'({ir8, ov8, res8}), 128'({2'b10, 16'h0}));
    @(negedge clk); rst8 = 1'b0;
    @(posedge clk); #1;
    check("abort_ready", 128'(ir8), 128'(1));
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ov8) seen = 1;
    end
    check("abort_no_valid", 128'(seen), 128'(0));

    // in_valid and operands wiggled during BUSY/DONE must not disturb op1.
    @(negedge clk); a8 = 8'd9; b8 = 8'd11; sm8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'd200; b8 = 8'd3;
    for (int k = 1; k <= 8; k++) begin
      iv8 = k[0];
      @(posedge clk); #1;
    end
    iv8 = 1'b1;
    check("ignore_result", 128'(res8), 128'(16'd99));
    repeat (2) @(posedge clk);
    #1;
    check("ignore_done_hold", 128'({ir8, ov8, res8}), 128'({2'b01, 16'd99}));
    @(negedge clk); or8 = 1'b1;
    @(posedge clk); #1; or8 = 1'b0;
    check("ignore_idle", 128'(ir8), 128'(1));
    @(posedge clk); #1; iv8 = 1'b0;
    check("second_accepted", 128'(ir8), 128'(0));
    repeat (8) @(posedge clk);
    #1;
    check("second_result", 128'({ov8, res8}), 128'({1'b1, 16'd600}));
    @(negedge clk); or8 = 1'b1;
    @(posedge clk); #1; or8 = 1'b0;

    for (int i = 0; i < 40; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), 0, "rand8");

    op64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, "s64_min_min");
    op64('1, '1, 1'b0, "u64_max_max");
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 300; i++)
        op64({$urandom, $urandom}, {$urandom, $urandom}, 1'(m), "rand64");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
